// File: rtl/pc_ir_unit_pkg.sv
// Shared encodings for the multicycle datapath: next-PC select codes and
// MIPS instruction field positions, plus small field helpers.
package pc_ir_unit_pkg;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_HOLD   = 2'b11
    } pc_src_e;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int JIDX_MSB  = 25;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // Pseudo-direct jump: region bits come from the PC before it updates.
    function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                                input logic [25:0] jidx);
        return {pc[31:28], jidx, 2'b00};
    endfunction

endpackage

// File: rtl/pc_ir_unit_pc_next_sel.sv
// Next-PC multiplexer and PC write-enable qualification.
module pc_next_sel
    import pc_ir_unit_pkg::*;
(
    input  logic        pc_write,
    input  logic        is_branch,
    input  logic        zero,
    input  logic [1:0]  pc_source,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] pc,
    input  logic [25:0] jump_index,
    output logic        pc_en,
    output logic [31:0] pc_next
);

    assign pc_en = pc_write | (is_branch & zero);

    // Select the candidate PC for the coming edge.
    always_comb begin
        pc_next = pc;
        case (pc_src_e'(pc_source))
            PC_ALU:    pc_next = alu_result;
            PC_ALUOUT: pc_next = alu_out;
            PC_JUMP:   pc_next = jump_target(pc, jump_index);
            PC_HOLD:   pc_next = pc;
            default:   pc_next = pc;
        endcase
    end

endmodule

// File: rtl/pc_ir_unit.sv
// Program counter, instruction register, MDR/ALUOut staging registers and
// fetch counter for a multicycle MIPS datapath.
module pc_ir_unit
    import pc_ir_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PCWrite,
    input  logic        isBranch,
    input  logic [1:0]  PCSource,
    input  logic        IRWrite,
    input  logic        lorD,
    input  logic [31:0] ALUResult,
    input  logic        Zero,
    input  logic [31:0] MemRdata,
    output logic [31:0] MemAddr,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic [5:0]  Op,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] SignImm,
    output logic [31:0] MDR,
    output logic [31:0] ALUOut,
    output logic [31:0] InstrCount
);

    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] mdr_r;
    logic [31:0] alu_out_r;
    logic [31:0] instr_count_r;
    logic        pc_en;
    logic [31:0] pc_next;

    pc_next_sel u_pc_next_sel (
        .pc_write   (PCWrite),
        .is_branch  (isBranch),
        .zero       (Zero),
        .pc_source  (PCSource),
        .alu_result (ALUResult),
        .alu_out    (alu_out_r),
        .pc         (pc_r),
        .jump_index (instr_r[JIDX_MSB:0]),
        .pc_en      (pc_en),
        .pc_next    (pc_next)
    );

    // Architectural state; reset overrides every load enable.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_r          <= RESET_PC;
            instr_r       <= 32'h0000_0000;
            mdr_r         <= 32'h0000_0000;
            alu_out_r     <= 32'h0000_0000;
            instr_count_r <= 32'h0000_0000;
        end else begin
            if (pc_en) begin
                pc_r <= pc_next;
            end
            if (IRWrite) begin
                instr_r       <= MemRdata;
                instr_count_r <= instr_count_r + 32'd1;
            end
            mdr_r     <= MemRdata;
            alu_out_r <= ALUResult;
        end
    end

    assign MemAddr    = lorD ? alu_out_r : pc_r;
    assign PC         = pc_r;
    assign Instr      = instr_r;
    assign MDR        = mdr_r;
    assign ALUOut     = alu_out_r;
    assign InstrCount = instr_count_r;

    assign Op      = instr_r[OP_MSB:OP_LSB];
    assign funct   = instr_r[FUNCT_MSB:FUNCT_LSB];
    assign rs      = instr_r[RS_MSB:RS_LSB];
    assign rt      = instr_r[RT_MSB:RT_LSB];
    assign rd      = instr_r[RD_MSB:RD_LSB];
    assign SignImm = sign_ext16(instr_r[IMM_MSB:0]);

endmodule

// File: doc/pc_ir_unit.md
PC_IR_UNIT -- requirements
Module: pc_ir_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port Clk  in  1  single clock; all state changes on posedge.
REQ-003 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port PCWrite  in  1  unconditional PC update enable from controller.
REQ-005 SHALL have port isBranch  in  1  conditional PC update enable (beq).
REQ-006 SHALL have port PCSource  in  2  next-PC select.
REQ-007 SHALL have port IRWrite  in  1  instruction register load enable.
REQ-008 SHALL have port lorD  in  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 SHALL have port ALUResult  in  32  current ALU output.
REQ-010 SHALL have port Zero  in  1  ALU zero flag.
REQ-011 SHALL have port MemRdata  in  32  memory read data.
REQ-012 SHALL have port MemAddr  out  32  memory address.
REQ-013 SHALL have port PC  out  32  program counter register.
REQ-014 SHALL have port Instr  out  32  instruction register.
REQ-015 SHALL have port Op  out  6  Instr[31:26], to controller; funct  out  6  Instr[5:0], to controller.
REQ-016 SHALL have ports rs, rt, rd  out  5 each  Instr[25:21], [20:16], [15:11].
REQ-017 SHALL have port SignImm  out  32  sign-extended Instr[15:0].
REQ-018 SHALL have port MDR  out  32  memory data register; ALUOut  out  32  ALU output register.
REQ-019 SHALL have port InstrCount  out  32  count of IR loads since reset.

Function
REQ-020 PC enable SHALL be PCWrite | (isBranch & Zero), evaluated in the same cycle.
REQ-021 Next PC SHALL be: PCSource 00 -> ALUResult; 01 -> ALUOut; 10 -> {PC[31:28], Instr[25:0], 2'b00}; 11 -> PC (hold).
REQ-022 PC SHALL load next PC on the posedge where enable is 1; otherwise it SHALL hold.
REQ-023 isBranch=1 with Zero=0 and PCWrite=0 SHALL leave PC unchanged.
REQ-024 Instr SHALL load MemRdata on a posedge with IRWrite=1, else hold; Op/funct/rs/rt/rd/SignImm SHALL be combinational slices of the registered Instr.
REQ-025 MDR SHALL load MemRdata every cycle; ALUOut SHALL load ALUResult every cycle (1-cycle latency).
REQ-026 MemAddr SHALL be combinational: lorD ? ALUOut : PC.
REQ-027 IRWrite and PCWrite in the same cycle (fetch) SHALL capture MemRdata fetched from the pre-update PC and load the new PC in the same edge.
REQ-028 Jump target SHALL use the registered Instr and the pre-update PC[31:28].
REQ-029 InstrCount SHALL increment by 1 on each posedge with IRWrite=1; it SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-030 Bits PC[1:0] SHALL be taken as loaded; no alignment correction is applied.

Reset
REQ-031 On a posedge with Reset=1: PC = RESET_PC, Instr = 0, MDR = 0, ALUOut = 0, InstrCount = 0.
REQ-032 Reset SHALL take priority over every enable, including mid-instruction; the first cycle after Reset deasserts SHALL present MemAddr = RESET_PC with lorD=0.

Structure
REQ-033 PCSource encodings (PC_ALU, PC_ALUOUT, PC_JUMP, PC_HOLD) and the MIPS field-position constants SHALL live in the shared package used by the controller.
REQ-034 The next-PC mux plus enable logic SHALL be one sub-module, pc_next_sel; all registers SHALL reside in pc_ir_unit.

Verification
REQ-035 Reset with RESET_PC=32'h0000_0040, then release -> PC=32'h40, MemAddr=32'h40, Instr=0, InstrCount=0.
REQ-036 Fetch: PCWrite=1, IRWrite=1, PCSource=00, ALUResult=PC+4, MemRdata=32'h0232_8020 -> next edge PC=PC+4, Instr=32'h02328020, Op=0, funct=6'h20, rs=17, rt=18, rd=16, InstrCount=1.
REQ-037 Branch: isBranch=1, PCSource=01, ALUOut=32'h100, Zero=1 -> PC=32'h100; repeat with Zero=0 -> PC unchanged.
REQ-038 Jump: Instr=32'h0800_0010, PC=32'h1000_0008, PCWrite=1, PCSource=10 -> PC=32'h1000_0040.
REQ-039 lw path: ALUResult=32'h200 one cycle, then lorD=1 -> MemAddr=32'h200; MemRdata=32'hDEAD_BEEF -> MDR=32'hDEADBEEF next edge; SignImm for Instr[15:0]=16'h8000 -> 32'hFFFF_8000.
REQ-040 Reset asserted during a PCWrite=1/IRWrite=1 cycle -> PC=RESET_PC, Instr=0; InstrCount preset to 32'hFFFF_FFFF then one IRWrite -> 0.
